uart_rx_frame: RTL

UART receiver that sits directly downstream of the team's UART transmitter on the serial line. Recovers frames of 1 start bit, 8 data bits LSB first, 1 parity bit and 1 stop bit, using an oversampled tick from a shared baud divider. Checks parity and framing, then presents each byte through a one-entry holding register with a valid/ack handshake.

---
 rtl/uart_rx_frame.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-flop line synchronizer, oversampled start/data/parity/stop
// recovery, and a one-entry holding register with valid/ack handshake and overrun pulse.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       sample_tick,
    input  logic       p_sel,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic          rx_meta_q;
    logic          rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic          done;

    logic [7:0]    data_q;
    logic          valid_q;
    logic          perr_out_q;
    logic          ferr_out_q;
    logic          overrun_q;

    // Both synchronizer flops reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        done    = 1'b0;
        if (sample_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        if (!rx_s_q) begin
                            cnt_d   = '0;
                            idx_d   = 3'd0;
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_END) begin
                        shift_d[idx_q] = rx_s_q;
                        cnt_d          = '0;
                        if (idx_q == 3'd7) begin
                            state_d = PARITY_EN ? S_PARITY : S_STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_END) begin
                        perr_d  = rx_s_q != (p_sel ? ^shift_q : ~^shift_q);
                        cnt_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    if (cnt_q == CNT_END) begin
                        done    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

    // Holding register: a completing frame wins over an ack in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done) begin
                if (!valid_q || data_ack) begin
                    data_q     <= shift_q;
                    perr_out_q <= PARITY_EN ? perr_q : 1'b0;
                    ferr_out_q <= ~rx_s_q;
                    valid_q    <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (data_ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_out_q;
    assign frame_err   = ferr_out_q;
    assign overrun_err = overrun_q;
    assign rx_busy     = (state_q != S_IDLE);
endmodule
